// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an LCD panel: h/v counters, sync/DE generation and
// a registered pixel stage with built-in test patterns or an external pixel stream.
module lcd_timing_gen #(
    parameter int H_ACTIVE   = 1366,
    parameter int H_FP       = 30,
    parameter int H_SYNC     = 114,
    parameter int H_BP       = 30,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 8,
    parameter int V_BP       = 2,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_W    = 6,
    parameter int NUM_BARS   = 4,
    parameter int CHECK_LOG2 = 5,
    parameter int CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    input  logic [3*COLOR_W-1:0] in_rgb,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 underflow_clr,
    output logic                 underflow,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [3*COLOR_W-1:0] rgb,
    output logic [CNT_W-1:0]     pos_x,
    output logic [CNT_W-1:0]     pos_y,
    output logic                 frame_start
);

    localparam int RGB_W   = 3 * COLOR_W;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_ACTIVE / NUM_BARS);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(NUM_BARS - 1);

    if (H_TOTAL >= 2**CNT_W || V_TOTAL >= 2**CNT_W || NUM_BARS < 1 || NUM_BARS > 8 ||
        H_ACTIVE < NUM_BARS || CHECK_LOG2 >= CNT_W) begin : g_param_check
        $error("lcd_timing_gen: illegal parameter set");
    end

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [1:0]       mode_q, mode_act;
    logic             frame_origin, active, hs_win, vs_win, uf_set, chk_odd;
    logic [CNT_W-1:0] bar_raw;
    logic [2:0]       bar_idx, bar_grb;
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic [CNT_W-1:0] pos_x_q, pos_y_q;
    logic             de_q, hsync_q, vsync_q, frame_start_q, underflow_q;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    // At the frame origin the mode input is used directly so the whole frame,
    // including its first pixel, sees the newly latched mode.
    assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign mode_act     = frame_origin ? mode : mode_q;
    assign active       = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hs_win       = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_win       = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign in_ready     = !rst && active && (mode_act == 2'd3);

    assign bar_raw = h_cnt_q / BAR_W;
    assign bar_idx = (bar_raw >= BAR_LAST) ? BAR_LAST[2:0] : bar_raw[2:0];
    assign chk_odd = h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2];

    // Bar palette as {G,R,B} enables
    always_comb begin
        bar_grb = 3'b000;
        unique case (bar_idx)
            3'd0: bar_grb = 3'b111;
            3'd1: bar_grb = 3'b110;
            3'd2: bar_grb = 3'b101;
            3'd3: bar_grb = 3'b100;
            3'd4: bar_grb = 3'b011;
            3'd5: bar_grb = 3'b010;
            3'd6: bar_grb = 3'b001;
            3'd7: bar_grb = 3'b000;
        endcase
    end

    always_comb begin
        rgb_d  = '0;
        uf_set = 1'b0;
        if (active) begin
            unique case (mode_act)
                2'd0: rgb_d = {{COLOR_W{bar_grb[2]}}, {COLOR_W{bar_grb[1]}}, {COLOR_W{bar_grb[0]}}};
                2'd1: rgb_d = solid_rgb;
                2'd2: rgb_d = {RGB_W{~chk_odd}};
                2'd3: begin
                    if (in_valid) rgb_d  = in_rgb;
                    else          uf_set = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_q        <= 2'd0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            rgb_q         <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            if (frame_origin) mode_q <= mode;
            de_q          <= active;
            hsync_q       <= hs_win ? HS_POL : ~HS_POL;
            vsync_q       <= vs_win ? VS_POL : ~VS_POL;
            rgb_q         <= rgb_d;
            if (active) begin
                pos_x_q <= h_cnt_q;
                pos_y_q <= v_cnt_q;
            end
            frame_start_q <= active && frame_origin;
            if (uf_set)             underflow_q <= 1'b1;
            else if (underflow_clr) underflow_q <= 1'b0;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a tiny 15x8 raster: patterns, external
// stream handshake, underflow flag, mid-frame mode change and mid-frame reset.
module tb_lcd_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [17:0] solid_rgb = '0;
    logic [17:0] in_rgb = '0;
    logic        in_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        in_ready, underflow, hsync, vsync, de, frame_start;
    logic [17:0] rgb;
    logic [11:0] pos_x, pos_y;

    int          n_vec = 0;
    int          n_miss = 0;
    int          ci = 0;
    logic [1:0]  m_act = 2'd0;
    logic        uf_e = 1'b0;
    int          lastx = 0;
    int          lasty = 0;
    int          rdy_cnt = 0;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(6), .NUM_BARS(3),
        .CHECK_LOG2(1), .CNT_W(12)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .in_rgb(in_rgb), .in_valid(in_valid), .in_ready(in_ready),
        .underflow_clr(underflow_clr), .underflow(underflow),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ramp(input int h, input int v);
        return 18'(h * 1031 + v * 97 + 677);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s @ci=%0d: observed %0h expected %0h", tag, ci, obs, exp);
        end
    endtask

    // One pixel clock: inputs for counter index ci are already driven; check
    // in_ready for ci, let the edge happen, then check the registered outputs.
    task automatic cyc();
        int          h, v;
        logic        act_e, de_e, hs_e, vs_e, fs_e, rdy_e;
        logic [1:0]  m_cur;
        logic [17:0] rgb_e;
        h = ci % 15;
        v = ci / 15;
        in_rgb = ramp(h, v);
        #1;
        act_e = (h < 8) && (v < 4);
        m_cur = (ci == 0) ? mode : m_act;
        rdy_e = !rst && act_e && (m_cur == 2'd3);
        chk("in_ready", 32'(in_ready), 32'(rdy_e));
        if (in_ready === 1'b1) rdy_cnt++;
        rgb_e = '0;
        if (rst) begin
            m_act = 2'd0;
            uf_e  = 1'b0;
            lastx = 0;
            lasty = 0;
            de_e  = 1'b0;
            hs_e  = 1'b1;
            vs_e  = 1'b1;
            fs_e  = 1'b0;
        end else begin
            m_act = m_cur;
            de_e  = act_e;
            hs_e  = !(h >= 10 && h < 13);
            vs_e  = !(v >= 5 && v < 7);
            fs_e  = act_e && (h == 0) && (v == 0);
            if (act_e) begin
                case (m_cur)
                    2'd0: rgb_e = (h < 2) ? 18'h3FFFF : (h < 4) ? 18'h3FFC0 : 18'h3F03F;
                    2'd1: rgb_e = solid_rgb;
                    2'd2: rgb_e = ((((h >> 1) ^ (v >> 1)) & 1) == 0) ? 18'h3FFFF : 18'h0;
                    default: rgb_e = in_valid ? in_rgb : 18'h0;
                endcase
                lastx = h;
                lasty = v;
            end
            if (act_e && m_cur == 2'd3 && !in_valid) uf_e = 1'b1;
            else if (underflow_clr)                  uf_e = 1'b0;
        end
        @(negedge clk);
        chk("de", 32'(de), 32'(de_e));
        chk("hsync", 32'(hsync), 32'(hs_e));
        chk("vsync", 32'(vsync), 32'(vs_e));
        chk("frame_start", 32'(frame_start), 32'(fs_e));
        chk("rgb", 32'(rgb), 32'(rgb_e));
        chk("pos_x", 32'(pos_x), 32'(lastx));
        chk("pos_y", 32'(pos_y), 32'(lasty));
        chk("underflow", 32'(underflow), 32'(uf_e));
        ci = rst ? 0 : (ci + 1) % 120;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Frame 1: colour bars, first DE right after release
        repeat (120) cyc();

        // Frame 2: checker
        mode = 2'd2;
        repeat (120) cyc();

        // Frame 3: external stream, always valid
        mode = 2'd3;
        in_valid = 1'b1;
        rdy_cnt = 0;
        repeat (120) cyc();
        chk("ready_per_frame", 32'(rdy_cnt), 32'd32);

        // Frame 4: one missing pixel at (3,1)
        for (int i = 0; i < 120; i++) begin
            in_valid = (i != 18);
            cyc();
        end
        in_valid = 1'b1;

        // Frame 5: flag holds; set+clear together at (5,2); clear alone at (9,5)
        for (int i = 0; i < 120; i++) begin
            in_valid      = (i != 35);
            underflow_clr = (i == 35) || (i == 84);
            cyc();
        end
        in_valid = 1'b1;
        underflow_clr = 1'b0;

        // Frame 6: solid, mode switched to checker mid-frame
        mode = 2'd1;
        solid_rgb = 18'h12345;
        for (int i = 0; i < 120; i++) begin
            if (i == 40) mode = 2'd2;
            if (i == 50) solid_rgb = 18'h2A5C3;
            cyc();
        end

        // Frame 7: checker takes over at frame start
        repeat (120) cyc();

        // Frame 8: external stream, reset at v=2, h=5, then bars from (0,0)
        mode = 2'd3;
        repeat (35) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mode = 2'd0;
        in_valid = 1'b0;
        repeat (122) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
